// File: rtl/ppd_burst_framer_if.sv
// ppd_burst_framer_if: detector write stream in, tagged valid/ready word stream out
interface ppd_burst_framer_if;
  logic [47:0] in_wrdata;
  logic        in_wrreq;
  logic [47:0] out_data;
  logic [1:0]  out_tag;
  logic        out_valid;
  logic        out_ready;
  modport master (output in_wrdata, in_wrreq, out_ready, input out_data, out_tag, out_valid);
  modport slave  (input in_wrdata, in_wrreq, out_ready, output out_data, out_tag, out_valid);
endinterface

// File: rtl/ppd_burst_framer.sv
// ppd_burst_framer: groups contiguous writes into header/data/trailer bursts buffered in a FIFO
// Define PPD_FRAMER_TIMESTAMP_EN to stamp header bits [47:32] with a free-running cycle count.
module ppd_burst_framer #(
  parameter int DEPTH = 512
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset_n,
  ppd_burst_framer_if.slave        bus,
  input  logic                     cfg_enable,
  input  logic [15:0]              cfg_gap_len,
  output logic [31:0]              stat_burst_count,
  output logic [31:0]              stat_drop_count,
  output logic [$clog2(DEPTH):0]   stat_fifo_level
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, BURST, SKIP} state_t;
  state_t        state_q, state_d;
  logic [47:0]   d_data_q, d_data_d;
  logic          d_vld_q, d_vld_d, flag_q, flag_d;
  logic [31:0]   burst_id_q, burst_id_d, cnt_q, cnt_d, drops_q, drops_d;
  logic [15:0]   gap_q, gap_d, gap_eff, ts;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   lvl_q, lvl_d;
  logic [49:0]   mem [DEPTH];
  logic [49:0]   wword, head;
  logic          wr, rd, drop, free1, free2, gap_hit;
`ifdef PPD_FRAMER_TIMESTAMP_EN
  logic [31:0] ts_q;
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) ts_q <= '0;
    else ts_q <= ts_q + 32'd1;
  assign ts = ts_q[15:0];
`else
  assign ts = '0;
`endif
  always_comb begin
    free1 = int'(lvl_q) < DEPTH;
    free2 = int'(lvl_q) + 2 <= DEPTH;
    gap_eff = cfg_gap_len < 16'd2 ? 16'd2 : cfg_gap_len;
    gap_hit = !bus.in_wrreq && (({1'b0, gap_q} + 17'd1) == {1'b0, gap_eff});
    gap_d = bus.in_wrreq ? '0 : gap_q + 16'd1;
    state_d = state_q;
    d_data_d = d_data_q;
    d_vld_d = 1'b0;
    flag_d = flag_q;
    burst_id_d = burst_id_q;
    cnt_d = cnt_q;
    wr = 1'b0;
    drop = 1'b0;
    wword = '0;
    case (state_q)
      IDLE: if (bus.in_wrreq) begin
        if (!cfg_enable) begin
          wr = free1;
          drop = !free1;
          wword = {2'b00, bus.in_wrdata};
        end else begin
          wr = free2;
          drop = !free2;
          wword = {2'b01, ts, burst_id_q};
          burst_id_d = burst_id_q + 32'd1;
          state_d = free2 ? BURST : SKIP;
          d_vld_d = free2;
          d_data_d = bus.in_wrdata;
          flag_d = 1'b0;
          cnt_d = 32'd1;
        end
      end
      BURST: begin
        if (d_vld_q) begin
          wr = free2;
          drop = !free2;
          wword = {2'b00, d_data_q};
          flag_d = flag_q | !free2;
        end else if (gap_hit) begin
          wr = 1'b1;
          wword = {2'b10, flag_q, 15'b0, cnt_q};
          state_d = IDLE;
        end
        if (bus.in_wrreq) begin
          d_vld_d = 1'b1;
          d_data_d = bus.in_wrdata;
          cnt_d = cnt_q + 32'd1;
        end
      end
      SKIP: begin
        drop = bus.in_wrreq;
        state_d = gap_hit ? IDLE : SKIP;
      end
      default: state_d = IDLE;
    endcase
    drops_d = (drop && !(&drops_q)) ? drops_q + 32'd1 : drops_q;
    rd = bus.out_valid && bus.out_ready;
    wp_d = wp_q + AW'(wr);
    rp_d = rp_q + AW'(rd);
    lvl_d = lvl_q + (AW+1)'(wr) - (AW+1)'(rd);
  end
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      state_q <= IDLE;
      d_data_q <= '0;
      d_vld_q <= 1'b0;
      flag_q <= 1'b0;
      burst_id_q <= '0;
      cnt_q <= '0;
      drops_q <= '0;
      gap_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      lvl_q <= '0;
    end else begin
      state_q <= state_d;
      d_data_q <= d_data_d;
      d_vld_q <= d_vld_d;
      flag_q <= flag_d;
      burst_id_q <= burst_id_d;
      cnt_q <= cnt_d;
      drops_q <= drops_d;
      gap_q <= gap_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      lvl_q <= lvl_d;
    end
  always_ff @(posedge clk_clk)
    if (wr) mem[wp_q] <= wword;
  assign head = mem[rp_q];
  assign bus.out_valid = lvl_q != '0;
  assign bus.out_data = bus.out_valid ? head[47:0] : '0;
  assign bus.out_tag = bus.out_valid ? head[49:48] : '0;
  assign stat_burst_count = burst_id_q;
  assign stat_drop_count = drops_q;
  assign stat_fifo_level = lvl_q;
endmodule

// File: tb/tb_ppd_burst_framer.sv
// tb_ppd_burst_framer: directed and random bursts scored against a queue-based reference model
module tb_ppd_burst_framer;
  localparam int DEPTH = 8;
  logic clk_clk = 1'b0;
  logic reset_reset_n = 1'b1;
  logic cfg_enable = 1'b1;
  logic [15:0] cfg_gap_len = 16'd4;
  logic [31:0] stat_burst_count, stat_drop_count;
  logic [$clog2(DEPTH):0] stat_fifo_level;
  int checks = 0, failures = 0;
  ppd_burst_framer_if bus();
  ppd_burst_framer #(.DEPTH(DEPTH)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .bus(bus),
    .cfg_enable(cfg_enable), .cfg_gap_len(cfg_gap_len),
    .stat_burst_count(stat_burst_count), .stat_drop_count(stat_drop_count),
    .stat_fifo_level(stat_fifo_level)
  );
  always #5 clk_clk = ~clk_clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  // Reference model: a word queue plus the burst/idle-run bookkeeping
  logic [49:0] exp_q[$];
  logic [47:0] pend[$];
  int mlvl = 0, mode = 0, quiet = 0, fr, g, w, r;
  logic [31:0] bid = 0, cnt = 0, drops = 0;
  bit flag = 0;
  always @(negedge clk_clk) begin
    if (!reset_reset_n) begin
      chk("rst_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_data", 64'(bus.out_data), 64'(0));
      chk("rst_tag", 64'(bus.out_tag), 64'(0));
      chk("rst_bursts", 64'(stat_burst_count), 64'(0));
      chk("rst_drops", 64'(stat_drop_count), 64'(0));
      chk("rst_level", 64'(stat_fifo_level), 64'(0));
      mlvl = 0; mode = 0; quiet = 0; cnt = 0; bid = 0; drops = 0; flag = 0;
      pend.delete();
      exp_q.delete();
    end else begin
      chk("valid", 64'(bus.out_valid), 64'(mlvl != 0));
      chk("level", 64'(stat_fifo_level), 64'(mlvl));
      chk("bursts", 64'(stat_burst_count), 64'(bid));
      chk("drops", 64'(stat_drop_count), 64'(drops));
      fr = DEPTH - mlvl;
      g = cfg_gap_len < 16'd2 ? 2 : int'(cfg_gap_len);
      r = (mlvl > 0 && bus.out_ready) ? 1 : 0;
      w = 0;
      case (mode)
        0: if (bus.in_wrreq) begin
          if (!cfg_enable) begin
            if (fr >= 1) begin exp_q.push_back({2'b00, bus.in_wrdata}); w = 1; end
            else drops++;
          end else begin
            if (fr >= 2) begin
              exp_q.push_back({2'b01, 16'h0, bid});
              w = 1;
              pend.push_back(bus.in_wrdata);
              flag = 0; cnt = 1; mode = 1;
            end else begin
              drops++;
              mode = 2;
            end
            bid++;
            quiet = 0;
          end
        end
        1: begin
          if (pend.size() > 0) begin
            if (fr >= 2) begin exp_q.push_back({2'b00, pend.pop_front()}); w = 1; end
            else begin void'(pend.pop_front()); drops++; flag = 1; end
          end
          if (bus.in_wrreq) begin
            pend.push_back(bus.in_wrdata);
            cnt++;
            quiet = 0;
          end else begin
            quiet++;
            if (quiet == g) begin
              exp_q.push_back({2'b10, flag, 15'b0, cnt});
              w = 1;
              mode = 0;
            end
          end
        end
        default: begin
          if (bus.in_wrreq) begin drops++; quiet = 0; end
          else begin quiet++; if (quiet == g) mode = 0; end
        end
      endcase
      mlvl = mlvl + w - r;
    end
  end
  always @(negedge clk_clk)
    if (reset_reset_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL word: got %0h expected none", {bus.out_tag, bus.out_data});
      end else chk("word", 64'({bus.out_tag, bus.out_data}), 64'(exp_q.pop_front()));
    end
  task automatic cyc(input bit req, input logic [47:0] dat);
    bus.in_wrreq = req;
    bus.in_wrdata = req ? dat : 48'({$urandom(), $urandom()});
    @(posedge clk_clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 48'h0);
  endtask
  initial begin
    bus.in_wrreq = 1'b0;
    bus.in_wrdata = '0;
    bus.out_ready = 1'b1;
    #1 reset_reset_n = 1'b0;
    repeat (3) @(posedge clk_clk);
    #1 reset_reset_n = 1'b1;
    cfg_gap_len = 16'd4;
    cyc(1, 48'h1); cyc(1, 48'h2); cyc(1, 48'h3); idle(8);
    chk("basic_bursts", 64'(stat_burst_count), 64'(1));
    cfg_gap_len = 16'd0;
    cyc(1, 48'h11); idle(1); cyc(1, 48'h12); idle(6);
    cyc(1, 48'h13); idle(2); cyc(1, 48'h14); idle(6);
    chk("gap_bursts", 64'(stat_burst_count), 64'(4));
    cfg_gap_len = 16'd4;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) cyc(1, 48'h20 + 48'(i));
    idle(6);
    chk("ovf_level", 64'(stat_fifo_level), 64'(8));
    chk("ovf_drops", 64'(stat_drop_count), 64'(4));
    bus.out_ready = 1'b1;
    idle(10);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) cyc(1, 48'h30 + 48'(i));
    idle(6);
    chk("skip_fill", 64'(stat_fifo_level), 64'(7));
    for (int i = 0; i < 3; i++) cyc(1, 48'h38 + 48'(i));
    idle(6);
    chk("skip_drops", 64'(stat_drop_count), 64'(7));
    chk("skip_level", 64'(stat_fifo_level), 64'(7));
    chk("skip_bursts", 64'(stat_burst_count), 64'(7));
    bus.out_ready = 1'b1;
    idle(10);
    cyc(1, 48'h40); idle(8);
    bus.out_ready = 1'b0;
    cyc(1, 48'h50); cyc(1, 48'h51); cyc(1, 48'h52);
    reset_reset_n = 1'b0;
    idle(2);
    reset_reset_n = 1'b1;
    bus.out_ready = 1'b1;
    cyc(1, 48'h60); idle(8);
    chk("post_rst_bursts", 64'(stat_burst_count), 64'(1));
    cfg_enable = 1'b0;
    cyc(1, 48'h71); cyc(1, 48'h72); cyc(1, 48'h73); idle(3);
    chk("bypass_bursts", 64'(stat_burst_count), 64'(1));
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        cfg_gap_len = 16'($urandom_range(0, 5));
        cfg_enable = $urandom_range(0, 3) != 0;
      end
      bus.out_ready = $urandom_range(0, 3) != 0;
      cyc($urandom_range(0, 2) != 0, 48'({$urandom(), $urandom()}));
    end
    cfg_enable = 1'b1;
    bus.out_ready = 1'b1;
    idle(40);
    chk("drain_queue", 64'(exp_q.size()), 64'(0));
    chk("drain_level", 64'(stat_fifo_level), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
